// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: control inputs, the instruction-memory
// port and the decode handoff. The sequencer uses the master view.
interface pc_sequencer_if;
  logic        start;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic        busy;

  modport master (
    input  start, halt, redirect, redirect_target, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst, inst_pc, inst_valid, pc, busy
  );

  modport slave (
    output start, halt, redirect, redirect_target, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, pc, busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Single-outstanding instruction fetch sequencer: FETCH issues a request at pc,
// HOLD parks the word for decode; halt and redirect preempt both.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MEM_LIMIT    = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Word-aligned and folded into the memory window in one AND.
  localparam logic [31:0] PC_MASK = 32'(MEM_LIMIT - 1) & ~32'd3;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;

  assign w_redir_pc = bus.redirect_target & PC_MASK;
  assign w_pc_inc   = (r_pc + 32'd4) & PC_MASK;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VECTOR;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
    end
  end

  // Priority inside the active states: halt, then redirect, then ack/ready.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (bus.redirect) w_pc_nxt = w_redir_pc;
        if (bus.start)    w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.halt) begin
          w_state_nxt      = S_HALTED;
          w_inst_valid_nxt = 1'b0;
        end else if (bus.redirect) begin
          w_pc_nxt         = w_redir_pc;
          w_inst_valid_nxt = 1'b0;
        end else if (bus.imem_ack) begin
          w_inst_nxt       = bus.imem_rdata;
          w_inst_pc_nxt    = r_pc;
          w_inst_valid_nxt = 1'b1;
          w_pc_nxt         = w_pc_inc;
          w_state_nxt      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.halt) begin
          w_state_nxt      = S_HALTED;
          w_inst_valid_nxt = 1'b0;
        end else if (bus.redirect) begin
          w_pc_nxt         = w_redir_pc;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_FETCH;
        end else if (r_inst_valid && bus.inst_ready) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.imem_req   = (r_state == S_FETCH);
  assign bus.imem_addr  = r_pc;
  assign bus.pc         = r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_inst_valid;
  assign bus.busy       = (r_state == S_FETCH) || (r_state == S_HOLD);

endmodule
